// File: rtl/bp_be_issue_buffer.sv
// Issue buffer between the FE queue and issue: speculative read, commit and replay.
// Optional same-cycle bypass of an empty buffer: define BP_BE_ISSUE_BUFFER_BYPASS_EN.
module bp_be_issue_buffer #(
    parameter int data_width_p = 128,
    parameter int depth_p      = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [data_width_p-1:0]       data_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [data_width_p-1:0]       data_o,
    output logic                          v_o,
    input  logic                          yumi_i,
    input  logic                          deq_i,
    input  logic                          roll_i,
    input  logic                          clr_i,
    input  logic                          poison_i,
    output logic                          poison_o,
    output logic [$clog2(depth_p):0]      occupancy_o
);

    localparam int ptr_w_lp = $clog2(depth_p) + 1;
    localparam int idx_w_lp = ptr_w_lp - 1;
    localparam logic [ptr_w_lp-1:0] one_lp  = ptr_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] full_lp = ptr_w_lp'(depth_p);

    logic [ptr_w_lp-1:0]     wptr_r;
    logic [ptr_w_lp-1:0]     rptr_r;
    logic [ptr_w_lp-1:0]     cptr_r;
    logic [ptr_w_lp-1:0]     cptr_n;
    logic [data_width_p-1:0] mem_r [depth_p];
    logic                    poison_r;
    logic                    rd_empty;
    logic                    enq;
    logic                    bypass;

    assign occupancy_o = wptr_r - cptr_r;
    assign ready_o     = (occupancy_o != full_lp) & ~clr_i & ~roll_i;
    assign enq         = v_i & ready_o;
    assign rd_empty    = (rptr_r == wptr_r);

`ifdef BP_BE_ISSUE_BUFFER_BYPASS_EN
    assign bypass = rd_empty & enq;
`else
    assign bypass = 1'b0;
`endif

    assign v_o      = (~rd_empty | bypass) & ~clr_i & ~roll_i;
    assign data_o   = bypass ? data_i : mem_r[rptr_r[idx_w_lp-1:0]];
    assign poison_o = v_o & (poison_r | poison_i);

    // deq is dropped during a flush; a replay rewinds to the post-commit pointer
    assign cptr_n = (deq_i & ~clr_i) ? cptr_r + one_lp : cptr_r;

    // Pointer update: reset/flush zero everything, roll wins over issue.
    always_ff @(posedge clk_i) begin
        if (reset_i | clr_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            if (enq)
                wptr_r <= wptr_r + one_lp;
            cptr_r <= cptr_n;
            if (roll_i)
                rptr_r <= cptr_n;
            else if (yumi_i)
                rptr_r <= rptr_r + one_lp;
        end
    end

    // Packet storage, left unreset; committed slots are simply overwritten.
    always_ff @(posedge clk_i) begin
        if (enq & ~reset_i)
            mem_r[wptr_r[idx_w_lp-1:0]] <= data_i;
    end

    // Sticky poison on the presented packet until it leaves or is replayed.
    always_ff @(posedge clk_i) begin
        if (reset_i | clr_i | roll_i | yumi_i)
            poison_r <= 1'b0;
        else if (poison_i & v_o)
            poison_r <= 1'b1;
    end

`ifndef SYNTHESIS
    // Committing an entry that was never issued corrupts the commit pointer.
    always @(posedge clk_i) begin
        if (!reset_i && !clr_i && deq_i)
            assert (cptr_r != rptr_r)
            else $error("bp_be_issue_buffer: deq_i with no issued entry");
    end
`endif

endmodule
